// File: rtl/spi_host_pkg.sv
// Shared types and SPI framing constants for the SPI host initiator.
// Imported by the RTL and by the bench's slave model.
package spi_host_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        NEXT  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_host_state_t;

    // Mode 0: SCLK idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL      = 1'b0;
    localparam logic SPI_CPHA      = 1'b0;
    localparam logic SPI_MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_host_div_tick.sv
// SCLK half-period divider: emits o_tick every CLK_DIV enabled cycles.
// Ports: i_clk, i_rst (sync, high), i_en (count), i_clear (reload), o_tick.
module spi_host_div_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // A clear restarts the full period so every state entry
    // waits exactly CLK_DIV cycles before its first tick.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= RELOAD;
        end else if (i_clear) begin
            r_cnt <= RELOAD;
        end else if (i_en) begin
            if (r_cnt == '0) r_cnt <= RELOAD;
            else             r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/spi_host_master.sv
// Mode-0, MSB-first, full-duplex SPI initiator with a valid/ready word port.
// Ports: i_clk, i_rst; tx: i_tx_valid/o_tx_ready/i_tx_data/i_tx_last;
//  rx: o_rx_valid/o_rx_data; o_busy; SPI: o_sclk, o_cs, o_mosi, i_miso.
module spi_host_master
    import spi_host_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_last,
    output logic              o_rx_valid,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_busy,
    output logic              o_sclk,
    output logic              o_cs,
    output logic              o_mosi,
    input  logic              i_miso
);

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("spi_host_master: CLK_DIV must be >= 2");
        end
        if (DATA_W < 8) begin : g_bad_w
            $error("spi_host_master: DATA_W must be >= 8");
        end
    endgenerate

    localparam int BW = $clog2(DATA_W + 1);

    spi_host_state_t r_state;
    spi_host_state_t w_state_nxt;

    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic [BW-1:0]     r_bit_cnt;
    logic              r_last;
    logic              r_rx_valid;
    logic              r_sclk;
    logic              r_cs;
    logic              r_mosi;

    logic w_tick;
    logic w_clear;
    logic w_div_en;
    logic w_tx_ready;
    logic w_accept;
    logic w_last_bit;
    logic w_load;
    logic w_fall;
    logic w_done;
    logic w_sclk_d;
    logic w_cs_d;
    logic w_mosi_d;

    assign w_tx_ready = (r_state == IDLE) || (r_state == NEXT);
    assign w_accept   = i_tx_valid && w_tx_ready;
    assign w_last_bit = (r_bit_cnt == BW'(DATA_W - 1));
    assign w_div_en   = !w_tx_ready;
    assign w_clear    = (r_state != w_state_nxt);

    spi_host_div_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_div_en),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, NEXT: begin
                if (w_accept) w_state_nxt = SETUP;
            end
            SETUP: begin
                if (w_tick) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (w_tick && r_sclk && w_last_bit)
                    w_state_nxt = r_last ? HOLD : NEXT;
            end
            HOLD: begin
                if (w_tick) w_state_nxt = GAP;
            end
            GAP: begin
                if (w_tick) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values for the registered SPI pins plus datapath strobes.
    always_comb begin
        w_sclk_d = 1'b0;
        w_cs_d   = r_cs;
        w_mosi_d = r_mosi;
        w_load   = 1'b0;
        w_fall   = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cs_d   = 1'b1;
                w_mosi_d = 1'b0;
                if (w_accept) begin
                    w_load   = 1'b1;
                    w_cs_d   = 1'b0;
                    w_mosi_d = i_tx_data[DATA_W-1];
                end
            end
            NEXT: begin
                if (w_accept) begin
                    w_load   = 1'b1;
                    w_mosi_d = i_tx_data[DATA_W-1];
                end
            end
            SETUP: begin
                w_sclk_d = w_tick;
            end
            SHIFT: begin
                w_sclk_d = w_tick ? !r_sclk : r_sclk;
                if (w_tick && r_sclk) begin
                    // Sample MISO on the falling-edge cycle: the
                    // slave has had the full high phase to settle.
                    w_fall = 1'b1;
                    if (w_last_bit) w_done   = 1'b1;
                    else            w_mosi_d = r_tx[DATA_W-2];
                end
            end
            HOLD: begin
                if (w_tick) w_cs_d = 1'b1;
            end
            GAP: begin
                w_cs_d   = 1'b1;
                w_mosi_d = 1'b0;
            end
            default: begin
                w_cs_d   = 1'b1;
                w_mosi_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_bit_cnt  <= '0;
            r_last     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_sclk     <= 1'b0;
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_sclk     <= w_sclk_d;
            r_cs       <= w_cs_d;
            r_mosi     <= w_mosi_d;
            r_rx_valid <= w_done;
            if (w_load) begin
                r_tx      <= i_tx_data;
                r_last    <= i_tx_last;
                r_bit_cnt <= '0;
            end
            if (w_fall) begin
                r_rx      <= {r_rx[DATA_W-2:0], i_miso};
                r_bit_cnt <= r_bit_cnt + BW'(1);
                if (!w_done) r_tx <= {r_tx[DATA_W-2:0], 1'b0};
            end
            if (w_done) r_rx_data <= {r_rx[DATA_W-2:0], i_miso};
        end
    end

    assign o_tx_ready = w_tx_ready;
    assign o_busy     = (r_state != IDLE);
    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_data;
    assign o_sclk     = r_sclk;
    assign o_cs       = r_cs;
    assign o_mosi     = r_mosi;

endmodule

// File: tb/tb_spi_host_master.sv
// Directed bench for spi_host_master: 32-bit/div-4 main instance with
// loopback or mode-0 slave model, plus an 8-bit/div-2 timing instance.
module tb_spi_host_master;
    import spi_host_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        tx_valid, tx_ready, tx_last;
    logic [31:0] tx_data, rx_data;
    logic        rx_valid, busy, sclk, cs, mosi, miso;

    logic        t_valid, t_ready, t_last;
    logic [7:0]  t_data, t_rxd;
    logic        t_rxv, t_busy, t_sclk, t_cs, t_mosi;

    logic        loop;
    logic [31:0] s_reply;
    logic [31:0] s_tx = '0;
    logic [31:0] s_rx = '0;
    logic        p_sclk = 1'b0;
    logic        p_cs = 1'b1;

    int n_rise = 0, n_strobe = 0, n_csfall = 0, n_csrise = 0, n_acc = 0;
    int n_tests = 0, n_fail = 0;

    assign miso = loop ? mosi : s_tx[31];

    spi_host_master #(.DATA_W(32), .CLK_DIV(4)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
        .i_tx_data(tx_data), .i_tx_last(tx_last),
        .o_rx_valid(rx_valid), .o_rx_data(rx_data),
        .o_busy(busy), .o_sclk(sclk), .o_cs(cs),
        .o_mosi(mosi), .i_miso(miso)
    );

    spi_host_master #(.DATA_W(8), .CLK_DIV(2)) u_small (
        .i_clk(clk), .i_rst(rst),
        .i_tx_valid(t_valid), .o_tx_ready(t_ready),
        .i_tx_data(t_data), .i_tx_last(t_last),
        .o_rx_valid(t_rxv), .o_rx_data(t_rxd),
        .o_busy(t_busy), .o_sclk(t_sclk), .o_cs(t_cs),
        .o_mosi(t_mosi), .i_miso(t_mosi)
    );

    // Mode-0 slave model plus event counters.
    always @(posedge clk) begin
        p_sclk <= sclk;
        p_cs   <= cs;
        if (p_cs && !cs)
            s_tx <= s_reply;
        else if (p_sclk && !sclk)
            s_tx <= {s_tx[30:0], 1'b0};
        if (!p_sclk && sclk) begin
            s_rx   <= {s_rx[30:0], mosi};
            n_rise <= n_rise + 1;
        end
        if (p_cs && !cs) n_csfall <= n_csfall + 1;
        if (!p_cs && cs) n_csrise <= n_csrise + 1;
        if (rx_valid)    n_strobe <= n_strobe + 1;
        if (tx_valid && tx_ready) n_acc <= n_acc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns at the negedge of the first cycle after the accept edge.
    task automatic start(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        while (!tx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 500), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_rx(output logic [31:0] rx, output int cyc);
        cyc = 1;
        while (!rx_valid && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("rx_timeout", 32'(cyc < 5000), 32'd1);
        rx = rx_data;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 500), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx;
        int cyc, r0, s0, f0, c0, a0, n;
        int c, r1, r2;
        logic ps;

        rst = 1'b1;
        tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
        t_valid = 1'b0;  t_data = '0;  t_last = 1'b0;
        loop = 1'b1;     s_reply = '0;
        repeat (3) @(negedge clk);

        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'(SPI_CPOL));
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_rxv", 32'(rx_valid), 32'd0);
        chk("rst_rxd", rx_data, 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_small_cs", 32'(t_cs), 32'd1);
        rst = 1'b0;

        // 1: loopback single word
        r0 = n_rise; s0 = n_strobe; f0 = n_csfall; c0 = n_csrise;
        start(32'hA5A5_0F0F, 1'b1);
        tx_valid = 1'b0;
        chk("t1_cs_low", 32'(cs), 32'd0);
        chk("t1_sclk_setup", 32'(sclk), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready", 32'(tx_ready), 32'd0);
        chk("t1_mosi_msb", 32'(mosi), 32'd1);
        wait_rx(rx, cyc);
        chk("t1_rx", rx, 32'hA5A5_0F0F);
        chk("t1_strobe_cyc", 32'(cyc), 32'd257);
        @(negedge clk);
        chk("t1_strobe_width", 32'(rx_valid), 32'd0);
        chk("t1_hold_cs", 32'(cs), 32'd0);
        wait_idle();
        chk("t1_rises", 32'(n_rise - r0), 32'd32);
        chk("t1_strobes", 32'(n_strobe - s0), 32'd1);
        chk("t1_csfall", 32'(n_csfall - f0), 32'd1);
        chk("t1_csrise", 32'(n_csrise - c0), 32'd1);
        chk("t1_idle_mosi", 32'(mosi), 32'd0);
        chk("t1_rxd_holds", rx_data, 32'hA5A5_0F0F);

        // 2: mode-0 slave returns a fixed word
        loop = 1'b0;
        s_reply = 32'hDEAD_BEEF;
        start(32'h0000_0000, 1'b1);
        tx_valid = 1'b0;
        wait_rx(rx, cyc);
        chk("t2_rx", rx, 32'hDEAD_BEEF);
        wait_idle();
        chk("t2_slave_rx", s_rx, 32'h0000_0000);
        loop = 1'b1;

        // 3: two-word burst, CS held low
        s0 = n_strobe; f0 = n_csfall; c0 = n_csrise;
        start(32'h1111_1111, 1'b0);
        tx_valid = 1'b0;
        wait_rx(rx, cyc);
        chk("t3_rx0", rx, 32'h1111_1111);
        repeat (10) @(negedge clk);
        chk("t3_next_ready", 32'(tx_ready), 32'd1);
        chk("t3_next_cs", 32'(cs), 32'd0);
        chk("t3_next_sclk", 32'(sclk), 32'd0);
        chk("t3_next_mosi", 32'(mosi), 32'd1);
        chk("t3_next_busy", 32'(busy), 32'd1);
        start(32'h2222_2222, 1'b1);
        tx_valid = 1'b0;
        wait_rx(rx, cyc);
        chk("t3_rx1", rx, 32'h2222_2222);
        chk("t3_cs_no_rise", 32'(n_csrise - c0), 32'd0);
        wait_idle();
        chk("t3_strobes", 32'(n_strobe - s0), 32'd2);
        chk("t3_csfall", 32'(n_csfall - f0), 32'd1);
        chk("t3_csrise", 32'(n_csrise - c0), 32'd1);

        // 4: valid held and data changed mid-frame
        a0 = n_acc;
        start(32'hCAFE_1234, 1'b1);
        repeat (40) @(negedge clk);
        tx_data = 32'hFFFF_FFFF;
        tx_last = 1'b0;
        chk("t4_ready_low", 32'(tx_ready), 32'd0);
        repeat (50) @(negedge clk);
        tx_data = 32'h0000_0000;
        wait_rx(rx, cyc);
        chk("t4_rx", rx, 32'hCAFE_1234);
        chk("t4_acc_strobe", 32'(n_acc - a0), 32'd1);
        tx_valid = 1'b0;
        wait_idle();
        chk("t4_acc_end", 32'(n_acc - a0), 32'd1);

        // 5: reset mid-shift, then a clean frame
        r0 = n_rise; s0 = n_strobe;
        start(32'h0F0F_0F0F, 1'b1);
        tx_valid = 1'b0;
        n = 0;
        while ((n_rise - r0) < 10 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_rise_timeout", 32'(n < 1000), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_cs", 32'(cs), 32'd1);
        chk("t5_sclk", 32'(sclk), 32'd0);
        chk("t5_mosi", 32'(mosi), 32'd0);
        chk("t5_rxv", 32'(rx_valid), 32'd0);
        chk("t5_rxd", rx_data, 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("t5_no_strobe", 32'(n_strobe - s0), 32'd0);
        start(32'h1234_5678, 1'b1);
        tx_valid = 1'b0;
        wait_rx(rx, cyc);
        chk("t5_rx", rx, 32'h1234_5678);
        chk("t5_strobe_cyc", 32'(cyc), 32'd257);
        wait_idle();

        // 6: 8-bit, CLK_DIV=2 timing
        @(negedge clk);
        t_valid = 1'b1;
        t_data  = 8'h5A;
        t_last  = 1'b1;
        chk("t6_ready", 32'(t_ready), 32'd1);
        @(negedge clk);
        t_valid = 1'b0;
        c = 1; r1 = 0; r2 = 0;
        chk("t6_cs_low", 32'(t_cs), 32'd0);
        ps = t_sclk;
        while (!t_rxv && c < 200) begin
            @(negedge clk);
            c++;
            if (!ps && t_sclk && r1 == 0)      r1 = c;
            else if (!ps && t_sclk && r2 == 0) r2 = c;
            ps = t_sclk;
        end
        chk("t6_strobe_cyc", 32'(c), 32'd33);
        chk("t6_first_rise", 32'(r1), 32'd3);
        chk("t6_period", 32'(r2 - r1), 32'd4);
        chk("t6_rx", 32'(t_rxd), 32'h5A);
        n = 0;
        while (t_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_idle", 32'(t_busy), 32'd0);
        chk("t6_cs_idle", 32'(t_cs), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
